vdcorput_fsm_param: RTL and testbench
=====================================

Name: vdcorput_fsm_param

Overview:
- Parametrised successor of the fixed 32-bit, four-base van der Corput FSM.
- Computes vdc(k, b) = sum over i of d_i * b^-(i+1), where d_i are the base-b digits of k, least-significant first.
- Result is an exact truncated unsigned fixed-point fraction with FRAC_W bits.
- Base is a run-time input (any value ≥ 2), not a 2-bit select. Serves as the per-axis generator under the Halton/disk/sphere samplers.

Parameters:
K_W, 32, width of index k_in.
BASE_W, 4, width of base_in; legal bases 2..2^BASE_W-1.
FRAC_W, 16, fractional bits of result; result = floor(vdc * 2^FRAC_W).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; accepted only when start && ready at a rising edge.
k_in  in  K_W  index, sampled on accept.
base_in  in  BASE_W  base, sampled on accept.
result  out  FRAC_W  fraction; held from done until the next accept.
done  out  1  one-cycle pulse when result/err are valid.
ready  out  1  high in IDLE only.
err  out  1  set with done when base < 2; cleared on next accept.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; result=0, done=0, err=0, ready=1.
  - Reset mid-operation aborts the computation and discards all internal values.
- Internal registers:
  - q: remaining quotient, K_W bits.
  - R: reversed numerator, K_W+BASE_W bits.
  - P: b^n, K_W+BASE_W bits.
  - rem: K_W+BASE_W+1 bits.
  - bit counter, latched b.
  - Invariants: R < P and P ≤ max(1, k*b), so there is no overflow.
- FSM states: IDLE, DIGIT, ACCUM, FRAC, DONE.
- IDLE: on accept, latch k and b; set q=k, R=0, P=1, clear err.
  - If b<2: go to DONE with err=1 and result=0.
  - Else if q==0: go to FRAC.
  - Else: go to DIGIT.
- DIGIT: restoring division q/b, one quotient bit per cycle, K_W cycles. Produces q' = q div b and d = q mod b.
- ACCUM: one cycle. R <= R*b + d, P <= P*b, q <= q'.
  - If q'==0, go to FRAC; else go to DIGIT.
  - Multiplication by b is combinational, width K_W+BASE_W.
- FRAC: FRAC_W cycles of restoring division with rem initialised to R.
  - Each cycle: rem <<= 1; if rem ≥ P then rem -= P and shift 1 into result, else shift 0.
  - Gives floor(R*2^FRAC_W / P) exactly.
- DONE: done=1 for one cycle, then return to IDLE. ready rises the cycle after done.
- Latency:
  - n = number of base-b digits of k (0 for k=0).
  - done is high L = n*(K_W+1) + FRAC_W + 1 rising edges after the accept edge.
  - Illegal base: L=1.
- Busy behaviour: start while ready=0 is ignored and does not queue. k_in/base_in may change freely while busy.
- Start held high continuously: a new accept occurs the first cycle ready is high, giving back-to-back operation with one IDLE cycle.
- Boundaries:
  - k=0 → result 0.
  - k=2^K_W-1, b=2 → all-ones result.
  - b = 2^BASE_W-1 must still be exact.

Decomposition:
- Package vdc_pkg holds:
  - the FSM state enum;
  - default widths K_W/BASE_W/FRAC_W;
  - localparam ACC_W = K_W+BASE_W.
- One sub-module, vdc_serial_divider (parameters K_W, BASE_W):
  - start/done handshake;
  - K_W-cycle restoring divide producing quotient and remainder;
  - used in DIGIT.
- FRAC division stays inline.

Test Plan:
1. FRAC_W=16, k=1, b=2 → result 0x8000, err=0, done exactly 1*33+17=50 cycles after accept.
2. k=1, b=3 → 0x5555. k=2, b=3 → 0xAAAA. k=6, b=2 → 0x6000 (latency 3*33+17=116). k=10, b=7 → 0x72F0.
3. k=0, b=5 → 0x0000 after 17 cycles. k=0xFFFFFFFF, b=2 → 0xFFFF. b=0 and b=1 → err=1, result 0, done 1 cycle after accept.
4. start pulsed mid-computation with different k → ignored, original result returned. start held high → back-to-back results with ready low during each run and a single IDLE cycle between.
5. rst_n dropped mid-DIGIT and mid-FRAC → outputs return to reset values immediately, with no done pulse. A following k=1, b=2 request returns 0x8000.
6. Random k/b sweep against a reference model floor(vdc*2^FRAC_W) with FRAC_W=24 and BASE_W=6 → bit-exact match and latency formula holds.

Source files
------------

// File: rtl/vdc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : vdc_pkg                                                   |
// | Description : Shared types and default widths for the parametrised     |
// |               van der Corput generator and its serial divider.         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package vdc_pkg;

  // Default widths: index, base and fractional result.
  localparam int VDC_K_W    = 32;
  localparam int VDC_BASE_W = 4;
  localparam int VDC_FRAC_W = 16;

  // Width of the reversed numerator R and of P = b^n.
  localparam int VDC_ACC_W  = VDC_K_W + VDC_BASE_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIGIT = 3'd1,
    S_ACCUM = 3'd2,
    S_FRAC  = 3'd3,
    S_DONE  = 3'd4
  } vdc_state_t;

endpackage
`default_nettype wire

// File: rtl/vdc_serial_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : vdc_serial_divider                                       |
// | Description : K_W-cycle restoring divider, one quotient bit per cycle. |
// |               Produces dividend div divisor and dividend mod divisor.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   start       begin a division; dividend/divisor are used in this cycle
//   dividend    K_W-bit numerator
//   divisor     BASE_W-bit denominator (must be >= 2)
//   quotient    quotient, valid from done until the next start
//   remainder   remainder, valid from done until the next start
//   done        one-cycle pulse, the cycle after the final quotient bit
module vdc_serial_divider
  import vdc_pkg::*;
#(
  parameter int K_W    = VDC_K_W,
  parameter int BASE_W = VDC_BASE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    dividend,
  input  logic [BASE_W-1:0] divisor,
  output logic [K_W-1:0]    quotient,
  output logic [BASE_W-1:0] remainder,
  output logic              done
);

  localparam int CNT_W = $clog2(K_W + 1);

  logic [K_W-1:0]    shreg_q, shreg_d;
  logic [BASE_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [K_W-1:0]    src;
  logic [BASE_W-1:0] rem_src;
  logic [BASE_W:0]   trial;
  logic              ge;
  logic              step;
  logic [CNT_W-1:0]  cnt_nxt;

  // The first step is taken on the start edge straight from the dividend
  // input, so the whole divide occupies exactly K_W cycles. Dividend bits
  // shift out of the top of shreg while quotient bits shift in at the bottom.
  always_comb begin
    src     = start ? dividend : shreg_q;
    rem_src = start ? '0 : rem_q;
    trial   = {rem_src, src[K_W-1]};
    ge      = (trial >= {1'b0, divisor});
    step    = start | busy_q;
    cnt_nxt = start ? CNT_W'(1) : cnt_q + 1'b1;

    shreg_d = shreg_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (step) begin
      shreg_d = {src[K_W-2:0], ge};
      // trial < 2*divisor, so the restored remainder always fits BASE_W bits.
      rem_d   = ge ? BASE_W'(trial - {1'b0, divisor}) : trial[BASE_W-1:0];
      cnt_d   = cnt_nxt;
      busy_d  = (cnt_nxt != CNT_W'(K_W));
      done_d  = (cnt_nxt == CNT_W'(K_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient  = shreg_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: rtl/vdcorput_fsm_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : vdcorput_fsm_param                                       |
// | Description : Run-time-base van der Corput generator. Returns          |
// |               floor(vdc(k, b) * 2^FRAC_W) exactly.                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   start       request; accepted when start && ready on a rising edge
//   k_in        index, sampled on accept
//   base_in     base, sampled on accept (legal 2 .. 2^BASE_W-1)
//   result      FRAC_W-bit fraction, held from done until the next accept
//   done        one-cycle pulse when result/err are valid
//   ready       high only while idle
//   err         raised with done when the base is below 2
module vdcorput_fsm_param
  import vdc_pkg::*;
#(
  parameter int K_W    = VDC_K_W,
  parameter int BASE_W = VDC_BASE_W,
  parameter int FRAC_W = VDC_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_in,
  input  logic [BASE_W-1:0] base_in,
  output logic [FRAC_W-1:0] result,
  output logic              done,
  output logic              ready,
  output logic              err
);

  localparam int ACC_W  = K_W + BASE_W;
  localparam int REM_W  = ACC_W + 1;
  localparam int FCNT_W = $clog2(FRAC_W + 1);

  vdc_state_t         state_q, state_d;
  logic [K_W-1:0]     q_q, q_d;
  logic [BASE_W-1:0]  b_q, b_d;
  logic [ACC_W-1:0]   r_q, r_d;
  logic [ACC_W-1:0]   p_q, p_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [FCNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0]  result_q, result_d;
  logic               err_q, err_d;

  logic               div_start;
  logic [K_W-1:0]     div_quot;
  logic [BASE_W-1:0]  div_rem;
  logic               div_done;

  logic [ACC_W-1:0]   b_ext;
  logic [ACC_W-1:0]   r_mac;
  logic [ACC_W-1:0]   p_mul;
  logic [REM_W-1:0]   rem_sh;
  logic               frac_ge;

  always_comb begin
    // R < P <= k*b < 2^ACC_W, so these products never overflow ACC_W bits.
    b_ext   = {{K_W{1'b0}}, b_q};
    r_mac   = r_q * b_ext + {{K_W{1'b0}}, div_rem};
    p_mul   = p_q * b_ext;
    rem_sh  = rem_q << 1;
    frac_ge = (rem_sh >= {1'b0, p_q});

    state_d  = state_q;
    q_d      = q_q;
    b_d      = b_q;
    r_d      = r_q;
    p_d      = p_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d      = base_in;
          q_d      = k_in;
          r_d      = '0;
          p_d      = ACC_W'(1);
          rem_d    = '0;
          cnt_d    = '0;
          result_d = '0;
          err_d    = 1'b0;
          if (base_in[BASE_W-1:1] == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (k_in == '0) begin
            state_d = S_FRAC;
          end else begin
            state_d = S_DIGIT;
          end
        end
      end

      S_DIGIT: begin
        if (div_done) state_d = S_ACCUM;
      end

      S_ACCUM: begin
        r_d = r_mac;
        p_d = p_mul;
        q_d = div_quot;
        if (div_quot == '0) begin
          rem_d   = {1'b0, r_mac};
          cnt_d   = '0;
          state_d = S_FRAC;
        end else begin
          state_d = S_DIGIT;
        end
      end

      S_FRAC: begin
        // Long division of R/P, one result bit per cycle, MSB first.
        rem_d    = frac_ge ? rem_sh - {1'b0, p_q} : rem_sh;
        result_d = {result_q[FRAC_W-2:0], frac_ge};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == FCNT_W'(FRAC_W - 1)) state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Kick the divider on every entry to DIGIT; it consumes the quotient
    // that is being loaded into q on the same edge.
    div_start = (state_d == S_DIGIT) && (state_q != S_DIGIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      p_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      b_q      <= b_d;
      r_q      <= r_d;
      p_q      <= p_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  vdc_serial_divider #(
    .K_W    (K_W),
    .BASE_W (BASE_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (q_d),
    .divisor   (b_d),
    .quotient  (div_quot),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign result = result_q;
  assign err    = err_q;
  assign done   = (state_q == S_DONE);
  assign ready  = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vdcorput_fsm_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_vdcorput_fsm_param                                    |
// | Description : Scoreboard bench for vdcorput_fsm_param (K_W=32,         |
// |               BASE_W=6, FRAC_W=24): directed corner cases, busy and    |
// |               back-to-back handshakes, reset abort, random sweep.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_vdcorput_fsm_param;

  localparam int K_W    = 32;
  localparam int BASE_W = 6;
  localparam int FRAC_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [K_W-1:0]    k_in = '0;
  logic [BASE_W-1:0] base_in = '0;
  logic [FRAC_W-1:0] result;
  logic              done, ready, err;

  vdcorput_fsm_param #(.K_W(K_W), .BASE_W(BASE_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_in(k_in), .base_in(base_in),
    .result(result), .done(done), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [FRAC_W-1:0] res;
    bit                err;
    int                lat;
    int                acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_done = -100;
  int   last_acc  = 0;

  // Directed cases with hand-derived 24-bit results.
  logic [31:0]       d_k [12] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd10, 32'd0,
                                  32'hFFFF_FFFF, 32'd5, 32'd5, 32'd63, 32'd62, 32'd14};
  int                d_b [12] = '{2, 3, 3, 2, 7, 5, 2, 0, 1, 63, 63, 15};
  logic [FRAC_W-1:0] d_r [12] = '{24'h800000, 24'h555555, 24'hAAAAAA, 24'h600000,
                                  24'h72F053, 24'h000000, 24'hFFFFFF, 24'h000000,
                                  24'h000000, 24'h001083, 24'hFBEFBE, 24'hEEEEEE};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: digits of k reversed into a fraction num/den = vdc(k,b),
  // then scaled by 2^FRAC_W and floored.
  function automatic void ref_model(input logic [31:0] k, input int b,
                                    output logic [FRAC_W-1:0] res, output bit e,
                                    output int lat);
    longint unsigned num, den, kk, bb;
    int n;
    if (b < 2) begin
      res = '0; e = 1'b1; lat = 1;
      return;
    end
    bb = longint'(b);
    num = 0; den = 1; kk = {32'd0, k}; n = 0;
    while (kk != 0) begin
      num = num * bb + kk % bb;
      den = den * bb;
      kk  = kk / bb;
      n++;
    end
    res = FRAC_W'((num << FRAC_W) / den);
    e   = 1'b0;
    lat = n * (K_W + 1) + FRAC_W + 1;
  endfunction

  task automatic wait_ready(output bit ok);
    int t = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!ready) begin
      t++;
      if (t > 3000) begin
        chk("ready_timeout", 64'd0, 64'd1);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [31:0] k, input int b, input bit use_exp,
                       input logic [FRAC_W-1:0] exp_res, input bit hold_start);
    bit ok;
    exp_t e;
    logic [FRAC_W-1:0] mres;
    bit merr;
    int mlat;
    wait_ready(ok);
    if (!ok) return;
    start   = 1'b1;
    k_in    = k;
    base_in = b[BASE_W-1:0];
    @(posedge clk);
    #1;
    ref_model(k, b, mres, merr, mlat);
    e.res = use_exp ? exp_res : mres;
    e.err = merr;
    e.lat = mlat;
    e.acc = cyc;
    sb.push_back(e);
    last_acc = cyc;
    if (!hold_start) start = 1'b0;
    // Inputs are free to wander while the request is in flight.
    k_in    = $urandom();
    base_in = BASE_W'($urandom());
  endtask

  // Monitor: pops one expectation per done pulse and checks handshakes.
  initial begin : monitor
    logic [FRAC_W-1:0] held;
    bit prev_done;
    exp_t e;
    held = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("ready_after_done", {63'd0, ready}, 64'd1);
        if (done) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("result", {40'd0, result}, {40'd0, e.res});
            chk("err", {63'd0, err}, {63'd0, e.err});
            chk("latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
            chk("ready_at_done", {63'd0, ready}, 64'd0);
            held = result;
            last_done = cyc;
          end
        end else if (sb.size() != 0) begin
          chk("ready_busy", {63'd0, ready}, 64'd0);
        end else begin
          chk("result_hold", {40'd0, result}, {40'd0, held});
        end
        prev_done = done;
      end
    end
  end

  initial begin : watchdog
    #900000;
    chk("watchdog", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : driver
    int b;
    int t;
    logic [31:0] k;

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_result", {40'd0, result}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    rst_n = 1'b1;

    // Directed corner cases.
    for (int i = 0; i < 12; i++) issue(d_k[i], d_b[i], 1'b1, d_r[i], 1'b0);

    // Start pulsed while busy must be ignored.
    issue(32'd10, 7, 1'b1, 24'h72F053, 1'b0);
    repeat (20) @(negedge clk);
    start = 1'b1; k_in = 32'd3; base_in = 6'd2;
    @(negedge clk);
    start = 1'b0;

    // Start held high: back-to-back runs, one idle cycle between them.
    for (int i = 0; i < 4; i++) begin
      issue($urandom_range(1, 5000), $urandom_range(2, 63), 1'b0, '0, 1'b1);
      if (i > 0) chk("b2b_gap", 64'(last_acc - last_done), 64'd2);
    end
    start = 1'b0;

    // Reset mid-DIGIT, then mid-FRAC.
    for (int i = 0; i < 2; i++) begin
      issue(32'd1, 2, 1'b1, 24'h800000, 1'b0);
      repeat ((i == 0) ? 10 : 40) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_result", {40'd0, result}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_err", {63'd0, err}, 64'd0);
      chk("abort_ready", {63'd0, ready}, 64'd1);
      sb.delete();
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
    end
    issue(32'd1, 2, 1'b1, 24'h800000, 1'b0);

    // Random sweep against the reference model.
    for (int i = 0; i < 120; i++) begin
      b = (i % 15 == 0) ? $urandom_range(0, 1) : $urandom_range(2, 63);
      case ($urandom_range(0, 3))
        0:       k = $urandom_range(0, 20);
        1:       k = 32'hFFFF_FFFF - $urandom_range(0, 5);
        default: k = $urandom();
      endcase
      issue(k, b, 1'b0, '0, 1'b0);
    end

    // Drain outstanding expectations.
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
